// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - three-port SRAM arbiter with tagged read return
// Port 0 has strict priority; ports 1 and 2 share a round-robin pointer.
module sram_access_arbiter #(
  parameter int READ_LATENCY = 3,
  parameter int ADDR_W       = 18
) (
  input  logic              Clock_50,
  input  logic              Reset,
  input  logic              Enable,
  input  logic [2:0]        Req,
  input  logic [2:0]        Req_we_n,
  input  logic [ADDR_W-1:0] Req_addr_0,
  input  logic [ADDR_W-1:0] Req_addr_1,
  input  logic [ADDR_W-1:0] Req_addr_2,
  input  logic [15:0]       Req_wdata_0,
  input  logic [15:0]       Req_wdata_1,
  input  logic [15:0]       Req_wdata_2,
  output logic [2:0]        Grant,
  output logic [2:0]        Rvalid,
  output logic [15:0]       Rdata,
  output logic              Busy,
  output logic [ADDR_W-1:0] SRAM_address,
  output logic [15:0]       SRAM_write_data,
  output logic              SRAM_we_n,
  input  logic [15:0]       SRAM_read_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic                           rr_q, rr_d;  // 0: port 1 wins a tie, 1: port 2 wins
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic [15:0]                    wdata_q, wdata_d;
  logic                           we_n_q, we_n_d;
  logic [READ_LATENCY-1:0]        tag_valid_q, tag_valid_d;
  logic [READ_LATENCY-1:0][1:0]   tag_port_q, tag_port_d;
  logic [15:0]                    rdata_q, rdata_d;

  logic [2:0] grant;
  logic [1:0] issue_port;
  logic       issue_read;
  logic       tags_empty;

  assign tags_empty = ~|tag_valid_q;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_n_d      = 1'b1;
    grant       = 3'b000;
    issue_port  = 2'd0;
    issue_read  = 1'b0;
    tag_valid_d = tag_valid_q;
    tag_port_d  = tag_port_q;
    rdata_d     = rdata_q;

    case (state_q)
      S_IDLE:  if (Enable) state_d = S_RUN;
      S_RUN:   if (!Enable) state_d = S_DRAIN;
      S_DRAIN: begin
        if (Enable)          state_d = S_RUN;
        else if (tags_empty) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_RUN && Enable) begin
      if (Req[0])                grant = 3'b001;
      else if (Req[1] && Req[2]) grant = rr_q ? 3'b100 : 3'b010;
      else if (Req[1])           grant = 3'b010;
      else if (Req[2])           grant = 3'b100;
    end

    case (grant)
      3'b001: begin
        addr_d = Req_addr_0; wdata_d = Req_wdata_0; we_n_d = Req_we_n[0]; issue_port = 2'd0;
      end
      3'b010: begin
        addr_d = Req_addr_1; wdata_d = Req_wdata_1; we_n_d = Req_we_n[1]; issue_port = 2'd1;
        rr_d   = 1'b1;
      end
      3'b100: begin
        addr_d = Req_addr_2; wdata_d = Req_wdata_2; we_n_d = Req_we_n[2]; issue_port = 2'd2;
        rr_d   = 1'b0;
      end
      default: ;
    endcase
    issue_read = (grant != 3'b000) && we_n_d;

    // Stage READ_LATENCY-1 is the return stage; it is loaded together with Rdata.
    for (int i = READ_LATENCY - 1; i > 0; i--) begin
      tag_valid_d[i] = tag_valid_q[i-1];
      tag_port_d[i]  = tag_port_q[i-1];
    end
    tag_valid_d[0] = issue_read;
    tag_port_d[0]  = issue_port;

    if (tag_valid_d[READ_LATENCY-1]) rdata_d = SRAM_read_data;
  end

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_n_q      <= 1'b1;
      tag_valid_q <= '0;
      tag_port_q  <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_n_q      <= we_n_d;
      tag_valid_q <= tag_valid_d;
      tag_port_q  <= tag_port_d;
      rdata_q     <= rdata_d;
    end
  end

  assign Grant           = grant;
  assign Rvalid          = tag_valid_q[READ_LATENCY-1] ? (3'b001 << tag_port_q[READ_LATENCY-1]) : 3'b000;
  assign Rdata           = rdata_q;
  assign Busy            = (state_q == S_RUN) || (state_q == S_DRAIN && !tags_empty);
  assign SRAM_address    = addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb/tb_sram_access_arbiter.sv - vector-table bench for sram_access_arbiter
// Includes a one-cycle registered SRAM emulator feeding SRAM_read_data.
module tb_sram_access_arbiter;

  logic        Clock_50 = 1'b0;
  logic        Reset;
  logic        Enable;
  logic [2:0]  Req;
  logic [2:0]  Req_we_n;
  logic [17:0] Req_addr_0, Req_addr_1, Req_addr_2;
  logic [15:0] Req_wdata_0, Req_wdata_1, Req_wdata_2;
  logic [2:0]  Grant;
  logic [2:0]  Rvalid;
  logic [15:0] Rdata;
  logic        Busy;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;

  sram_access_arbiter #(.READ_LATENCY(3), .ADDR_W(18)) dut (
    .Clock_50(Clock_50), .Reset(Reset), .Enable(Enable), .Req(Req), .Req_we_n(Req_we_n),
    .Req_addr_0(Req_addr_0), .Req_addr_1(Req_addr_1), .Req_addr_2(Req_addr_2),
    .Req_wdata_0(Req_wdata_0), .Req_wdata_1(Req_wdata_1), .Req_wdata_2(Req_wdata_2),
    .Grant(Grant), .Rvalid(Rvalid), .Rdata(Rdata), .Busy(Busy),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data)
  );

  always #5 Clock_50 = ~Clock_50;

  // Unwritten words read as 0xA000+addr, except 0x10 which holds 0xBEEF.
  bit   [15:0] mem     [262144];
  bit          written [262144];
  logic [15:0] rd_q = 16'h0000;

  function automatic logic [15:0] dflt(input logic [17:0] a);
    return (a == 18'h10) ? 16'hBEEF : (16'hA000 + a[15:0]);
  endfunction

  always @(posedge Clock_50) begin
    if (!SRAM_we_n) begin
      mem[SRAM_address]     <= SRAM_write_data;
      written[SRAM_address] <= 1'b1;
    end
    rd_q <= written[SRAM_address] ? mem[SRAM_address] : dflt(SRAM_address);
  end
  assign SRAM_read_data = rd_q;

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  we_n;
    logic [17:0] a0, a1, a2;
    logic [15:0] wd1, wd2;
    logic [2:0]  g;
    logic        swe;
    logic [17:0] sadr;
    logic [2:0]  rv;
    logic [15:0] rd;
    logic        busy;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic [2:0] req, input logic [2:0] we_n,
                     input logic [17:0] a0, input logic [17:0] a1, input logic [17:0] a2,
                     input logic [15:0] wd1, input logic [15:0] wd2,
                     input logic [2:0] g, input logic swe, input logic [17:0] sadr,
                     input logic [2:0] rv, input logic [15:0] rd, input logic busy);
    vec_t v;
    v.req = req; v.we_n = we_n; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.wd1 = wd1; v.wd2 = wd2;
    v.g = g; v.swe = swe; v.sadr = sadr; v.rv = rv; v.rd = rd; v.busy = busy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int step, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", nm, step, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock_50);
    #1;
  endtask

  task automatic idle_inputs();
    Req = 3'b000; Req_we_n = 3'b111;
    Req_addr_0 = '0; Req_addr_1 = '0; Req_addr_2 = '0;
    Req_wdata_0 = '0; Req_wdata_1 = '0; Req_wdata_2 = '0;
  endtask

  initial begin
    Reset = 1'b1; Enable = 1'b1;
    idle_inputs();
    Req = 3'b111;
    repeat (2) tick();
    #2;
    chk("reset_grant", 0, Grant, 3'b000);
    chk("reset_addr", 0, SRAM_address, 18'h0);
    chk("reset_wdata", 0, SRAM_write_data, 16'h0);
    chk("reset_we_n", 0, SRAM_we_n, 1'b1);
    chk("reset_rvalid", 0, Rvalid, 3'b000);
    chk("reset_rdata", 0, Rdata, 16'h0);
    chk("reset_busy", 0, Busy, 1'b0);

    tick();
    Enable = 1'b0; idle_inputs(); Reset = 1'b0;

    // single read from port 2
    add(3'b000, 3'b111, 0, 0, 0, 0, 0, 3'b000, 1, 18'h00, 3'b000, 16'h0, 0);
    add(3'b100, 3'b111, 0, 0, 18'h10, 0, 0, 3'b100, 1, 18'h00, 3'b000, 16'h0, 1);
    add(3'b000, 3'b111, 0, 0, 0, 0, 0, 3'b000, 1, 18'h10, 3'b000, 16'h0, 1);
    add(3'b000, 3'b111, 0, 0, 0, 0, 0, 3'b000, 1, 18'h10, 3'b000, 16'h0, 1);
    add(3'b000, 3'b111, 0, 0, 0, 0, 0, 3'b000, 1, 18'h10, 3'b100, 16'hBEEF, 1);
    // ports 1 and 2 write continuously
    add(3'b110, 3'b001, 0, 18'h20, 18'h30, 16'h1111, 16'h2222, 3'b010, 1, 18'h10, 3'b000, 16'h0, 1);
    add(3'b110, 3'b001, 0, 18'h20, 18'h30, 16'h1111, 16'h2222, 3'b100, 0, 18'h20, 3'b000, 16'h0, 1);
    add(3'b110, 3'b001, 0, 18'h20, 18'h30, 16'h1111, 16'h2222, 3'b010, 0, 18'h30, 3'b000, 16'h0, 1);
    add(3'b110, 3'b001, 0, 18'h20, 18'h30, 16'h1111, 16'h2222, 3'b100, 0, 18'h20, 3'b000, 16'h0, 1);
    add(3'b000, 3'b111, 0, 0, 0, 0, 0, 3'b000, 0, 18'h30, 3'b000, 16'h0, 1);
    add(3'b000, 3'b111, 0, 0, 0, 0, 0, 3'b000, 1, 18'h30, 3'b000, 16'h0, 1);
    // port 0 streams 8 reads while ports 1 and 2 wait
    add(3'b111, 3'b111, 18'h20, 18'h40, 18'h41, 0, 0, 3'b001, 1, 18'h30, 3'b000, 16'h0, 1);
    add(3'b111, 3'b111, 18'h30, 18'h40, 18'h41, 0, 0, 3'b001, 1, 18'h20, 3'b000, 16'h0, 1);
    add(3'b111, 3'b111, 18'h10, 18'h40, 18'h41, 0, 0, 3'b001, 1, 18'h30, 3'b000, 16'h0, 1);
    add(3'b111, 3'b111, 18'h00, 18'h40, 18'h41, 0, 0, 3'b001, 1, 18'h10, 3'b001, 16'h1111, 1);
    add(3'b111, 3'b111, 18'h01, 18'h40, 18'h41, 0, 0, 3'b001, 1, 18'h00, 3'b001, 16'h2222, 1);
    add(3'b111, 3'b111, 18'h02, 18'h40, 18'h41, 0, 0, 3'b001, 1, 18'h01, 3'b001, 16'hBEEF, 1);
    add(3'b111, 3'b111, 18'h03, 18'h40, 18'h41, 0, 0, 3'b001, 1, 18'h02, 3'b001, 16'hA000, 1);
    add(3'b111, 3'b111, 18'h04, 18'h40, 18'h41, 0, 0, 3'b001, 1, 18'h03, 3'b001, 16'hA001, 1);
    add(3'b110, 3'b111, 0, 18'h40, 18'h41, 0, 0, 3'b010, 1, 18'h04, 3'b001, 16'hA002, 1);
    add(3'b100, 3'b111, 0, 18'h40, 18'h41, 0, 0, 3'b100, 1, 18'h40, 3'b001, 16'hA003, 1);
    add(3'b000, 3'b111, 0, 0, 0, 0, 0, 3'b000, 1, 18'h41, 3'b001, 16'hA004, 1);
    add(3'b000, 3'b111, 0, 0, 0, 0, 0, 3'b000, 1, 18'h41, 3'b010, 16'hA040, 1);
    add(3'b000, 3'b111, 0, 0, 0, 0, 0, 3'b000, 1, 18'h41, 3'b100, 16'hA041, 1);
    // read, write, read-after-write on consecutive grants
    add(3'b001, 3'b111, 18'h5, 0, 0, 0, 0, 3'b001, 1, 18'h41, 3'b000, 16'h0, 1);
    add(3'b100, 3'b011, 0, 0, 18'h6, 0, 16'h1234, 3'b100, 1, 18'h05, 3'b000, 16'h0, 1);
    add(3'b001, 3'b111, 18'h6, 0, 0, 0, 0, 3'b001, 0, 18'h06, 3'b000, 16'h0, 1);
    add(3'b000, 3'b111, 0, 0, 0, 0, 0, 3'b000, 1, 18'h06, 3'b001, 16'hA005, 1);
    add(3'b000, 3'b111, 0, 0, 0, 0, 0, 3'b000, 1, 18'h06, 3'b000, 16'h0, 1);
    add(3'b000, 3'b111, 0, 0, 0, 0, 0, 3'b000, 1, 18'h06, 3'b001, 16'h1234, 1);

    foreach (vecs[i]) begin
      tick();
      Enable = 1'b1;
      Req = vecs[i].req; Req_we_n = vecs[i].we_n;
      Req_addr_0 = vecs[i].a0; Req_addr_1 = vecs[i].a1; Req_addr_2 = vecs[i].a2;
      Req_wdata_0 = 16'h0; Req_wdata_1 = vecs[i].wd1; Req_wdata_2 = vecs[i].wd2;
      #2;
      chk("grant", i, Grant, vecs[i].g);
      chk("sram_we_n", i, SRAM_we_n, vecs[i].swe);
      chk("sram_addr", i, SRAM_address, vecs[i].sadr);
      chk("rvalid", i, Rvalid, vecs[i].rv);
      chk("busy", i, Busy, vecs[i].busy);
      if (vecs[i].rv != 3'b000) chk("rdata", i, Rdata, vecs[i].rd);
    end

    // two reads then Enable drops with requests still pending
    tick(); idle_inputs(); Req = 3'b001; Req_addr_0 = 18'h10; #2;
    chk("drain_g0", 100, Grant, 3'b001);
    tick(); Req_addr_0 = 18'h20; #2;
    chk("drain_g1", 101, Grant, 3'b001);
    tick(); Enable = 1'b0; Req = 3'b111; #2;
    chk("drain_nogrant2", 102, Grant, 3'b000);
    chk("drain_busy2", 102, Busy, 1'b1);
    tick(); #2;
    chk("drain_nogrant3", 103, Grant, 3'b000);
    chk("drain_busy3", 103, Busy, 1'b1);
    chk("drain_rv3", 103, Rvalid, 3'b001);
    chk("drain_rd3", 103, Rdata, 16'hBEEF);
    tick(); #2;
    chk("drain_busy4", 104, Busy, 1'b1);
    chk("drain_rv4", 104, Rvalid, 3'b001);
    chk("drain_rd4", 104, Rdata, 16'h1111);
    tick(); #2;
    chk("drain_busy5", 105, Busy, 1'b0);
    chk("drain_rv5", 105, Rvalid, 3'b000);
    chk("drain_nogrant5", 105, Grant, 3'b000);
    tick(); Req = 3'b000; #2;
    chk("drain_idle", 106, dut.state_q, 2'd0);
    chk("drain_busy6", 106, Busy, 1'b0);

    // reset one cycle after a read grant drops that read
    tick(); Enable = 1'b1; #2;
    chk("rst_run_nogrant", 107, Grant, 3'b000);
    tick(); Req = 3'b100; Req_we_n = 3'b111; Req_addr_2 = 18'h10; #2;
    chk("rst_pre_grant", 108, Grant, 3'b100);
    tick(); Req = 3'b000; Reset = 1'b1; #2;
    chk("rst_addr", 109, SRAM_address, 18'h0);
    chk("rst_we_n", 109, SRAM_we_n, 1'b1);
    chk("rst_busy", 109, Busy, 1'b0);
    chk("rst_rdata", 109, Rdata, 16'h0);
    chk("rst_rvalid", 109, Rvalid, 3'b000);
    tick(); Reset = 1'b0; Enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #2;
      chk("rst_no_rvalid", 110 + k, Rvalid, 3'b000);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
